hub75_scanout: RTL
==================

Name: hub75_scanout

Overview:
- Read-side engine for the pixel RAM blocks. It scans two 256x16 pixel RAMs, one for the upper half of the panel and one for the lower half, and drives a 32x16, 1/8-scan HUB75 LED panel.
- Colour depth comes from binary-code modulation over 5 bit planes of RGB555 pixel data.
- The block sits between the pixel RAM pair and the panel connector. It is the only reader of the RAMs' read ports.

Parameters:
- COLS, 32, pixels per panel row; COLS*ROWS_HALF must equal 256.
- ROWS_HALF, 8, scan rows per half-panel (row address range 0..7).
- PLANES, 5, bit planes per colour channel.
- DISPLAY_BASE, 16, OE-on cycles for plane 0; plane p displays DISPLAY_BASE<<p cycles.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  scan enable; sampled at row/plane boundaries only.
- o_r_addr  out  8  shared read address to both RAMs; address = row*COLS + col.
- o_r_enable  out  1  read enable to both RAMs.
- i_upper_data  in  16  upper-RAM read data, valid the cycle after o_r_enable.
- i_lower_data  in  16  lower-RAM read data, same timing.
- o_rgb1  out  3  {R,G,B} bits for the upper-half pixel.
- o_rgb2  out  3  {R,G,B} bits for the lower-half pixel.
- o_panel_clk  out  1  panel shift clock.
- o_lat  out  1  panel latch, active high.
- o_oe_n  out  1  panel output enable, active low.
- o_row  out  3  panel row address A..C.
- o_frame_done  out  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Reset (async assert, sync release): o_r_addr=0, o_r_enable=0, o_rgb1=0, o_rgb2=0, o_panel_clk=0, o_lat=0, o_oe_n=1, o_row=0, o_frame_done=0. Internal row=0, plane=0, col=0, state=IDLE.
- Pixel format: R=[14:10], G=[9:5], B=[4:0]. Bit 15 is ignored. Plane p selects bit p of each channel.
- IDLE: o_oe_n=1. Leaves for SHIFT on the cycle after i_enable=1. Returns to IDLE only at a plane boundary when i_enable=0, and resumes at the same row and plane.
- SHIFT: 3 cycles per column, col 0..COLS-1.
  - Phase C0: o_r_addr=row*COLS+col, o_r_enable=1, o_panel_clk=0.
  - Phase C1: o_r_enable=0; o_rgb1/o_rgb2 register the plane-p bits of i_upper_data/i_lower_data; o_panel_clk=0.
  - Phase C2: o_panel_clk=1; RGB held. col increments.
  - After the C2 of col COLS-1, go to LATCH.
- LATCH, 1 cycle: o_panel_clk=0, o_lat=1, o_oe_n=1, o_row=row. o_row changes only here, while OE is off.
- DISPLAY: o_oe_n=0 for exactly DISPLAY_BASE<<plane cycles, counter width sufficient for DISPLAY_BASE<<(PLANES-1).
- BLANK, 1 cycle: o_oe_n=1. Then plane increments.
  - When plane wraps from PLANES-1 to 0, row increments.
  - When row wraps from ROWS_HALF-1 to 0, o_frame_done=1 for this BLANK cycle only.
  - Next state is SHIFT if i_enable=1, else IDLE.
- o_oe_n is never low during SHIFT or LATCH. o_lat is never high while o_oe_n=0.
- Per-plane cycle count is COLS*3 + 1 + (DISPLAY_BASE<<p) + 1. With defaults, plane 0 is 114 cycles and plane 4 is 354 cycles.
- One frame is ROWS_HALF*sum over planes; with defaults 8*(5*98 + 496) = 7888 cycles.
- i_enable dropping mid-plane has no effect until BLANK. Reset mid-operation returns immediately to reset values, with o_oe_n=1 asynchronously.
- RAM writes may occur concurrently. The scanout reads whatever data is present; no tearing protection is provided.

Test Plan:
- Reset, i_enable=0 for 50 cycles -> all outputs hold reset values; o_oe_n=1; no o_r_enable pulses.
- Upper RAM all 16'h7C00, lower all 16'h001F, enable -> plane 0: o_rgb1=3'b100 and o_rgb2=3'b001 on every o_panel_clk rise; exactly 32 rises before the first o_lat.
- Address check -> o_r_addr sequence is 0..31 in row 0 (five times, once per plane), then 32..63 in row 1. Each o_r_enable is high for exactly 1 cycle, every 3 cycles.
- OE width -> o_oe_n low for 16, 32, 64, 128, 256 cycles for planes 0..4. o_row changes only in o_lat cycles.
- Full frame -> o_frame_done pulses once, 7888 cycles after scan start, with the pulse coincident with the BLANK after row 7 plane 4. The next o_r_addr is 0.
- i_enable dropped mid-DISPLAY of row 3 plane 2 -> plane completes, block enters IDLE. Re-enabling resumes at row 3 plane 3 (o_r_addr=96). Asserting i_rst_n=0 mid-SHIFT forces o_oe_n=1 and o_r_addr=0 immediately.

Source files
------------

// File: rtl/hub75_scanout_if.sv
// Pixel RAM read-port bundle shared by the upper and lower half-panel RAMs.
//   r_addr     : read address, common to both RAMs (row*COLS + col)
//   r_enable   : read strobe, common to both RAMs
//   upper_data : upper-half RAM read data, valid the cycle after r_enable
//   lower_data : lower-half RAM read data, same timing
// master = the scanout engine, slave = the RAM pair.
interface hub75_scanout_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] r_addr;
    logic          r_enable;
    logic [DW-1:0] upper_data;
    logic [DW-1:0] lower_data;

    modport master (output r_addr, output r_enable, input upper_data, input lower_data);
    modport slave  (input r_addr, input r_enable, output upper_data, output lower_data);
endinterface

// File: rtl/hub75_scanout.sv
// HUB75 scanout engine: reads the upper/lower pixel RAM pair and drives a
// 1/8-scan panel using binary-code modulation over PLANES bit planes of
// RGB555 data.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_enable       : scan enable, honoured only at plane boundaries
//   ram            : shared read port to both pixel RAMs (master side)
//   o_rgb1/o_rgb2  : {R,G,B} plane bits for upper/lower half pixel
//   o_panel_clk    : shift clock, o_lat : latch, o_oe_n : output enable
//   o_row          : row address A..C, o_frame_done : end-of-frame pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | panel dark, waiting for i_enable; row/plane are retained
// SHIFT    | 3 phases per column: read, capture RGB, panel clock high
// LATCH    | one cycle latch pulse, row address updated here
// DISPLAY  | OE on for DISPLAY_BASE<<plane cycles (down-counter)
// BLANK    | OE off, advance plane/row, flag frame end
module hub75_scanout #(
    parameter int COLS         = 32,
    parameter int ROWS_HALF    = 8,
    parameter int PLANES       = 5,
    parameter int DISPLAY_BASE = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    hub75_scanout_if.master  ram,
    output logic [2:0]       o_rgb1,
    output logic [2:0]       o_rgb2,
    output logic             o_panel_clk,
    output logic             o_lat,
    output logic             o_oe_n,
    output logic [2:0]       o_row,
    output logic             o_frame_done
);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS_HALF);
    localparam int PL_W   = $clog2(PLANES);
    localparam int DCNT_W = $clog2((DISPLAY_BASE << (PLANES - 1)) + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT, ST_LATCH, ST_DISPLAY, ST_BLANK
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [2:0]          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic [2:0]          row_out_q, row_out_d;
    logic [7:0]          r_addr_q, r_addr_d;
    logic                r_enable_q, r_enable_d;
    logic                panel_clk_q, panel_clk_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic                frame_done_q, frame_done_d;
    logic                last_plane, last_row;

    logic [4:0] up_r, up_g, up_b, lo_r, lo_g, lo_b;
    logic       unused_msb;

    assign up_r = ram.upper_data[14:10];
    assign up_g = ram.upper_data[9:5];
    assign up_b = ram.upper_data[4:0];
    assign lo_r = ram.lower_data[14:10];
    assign lo_g = ram.lower_data[9:5];
    assign lo_b = ram.lower_data[4:0];
    assign unused_msb = ram.upper_data[15] ^ ram.lower_data[15];

    assign last_plane = (plane_q == PL_W'(PLANES - 1));
    assign last_row   = (row_q == ROW_W'(ROWS_HALF - 1));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        plane_d   = plane_q;
        dcnt_d    = dcnt_q;
        rgb1_d    = rgb1_q;
        rgb2_d    = rgb2_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                case (phase_q)
                    2'd0: phase_d = 2'd1;
                    2'd1: begin
                        // RAM data for the read issued in phase 0 is valid now.
                        phase_d = 2'd2;
                        rgb1_d  = {up_r[plane_q], up_g[plane_q], up_b[plane_q]};
                        rgb2_d  = {lo_r[plane_q], lo_g[plane_q], lo_b[plane_q]};
                    end
                    default: begin
                        phase_d = 2'd0;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d   = '0;
                            state_d = ST_LATCH;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                endcase
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
                dcnt_d  = DCNT_W'((DISPLAY_BASE << plane_q) - 1);
            end
            ST_DISPLAY: begin
                if (dcnt_q == '0) state_d = ST_BLANK;
                else              dcnt_d  = dcnt_q - DCNT_W'(1);
            end
            ST_BLANK: begin
                if (last_plane) begin
                    plane_d = '0;
                    row_d   = last_row ? '0 : row_q + ROW_W'(1);
                end else begin
                    plane_d = plane_q + PL_W'(1);
                end
                state_d = i_enable ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Panel/RAM outputs are registered from the next-state view so they
        // line up with the state they belong to and never glitch.
        r_addr_d     = 8'(int'(row_d) * COLS + int'(col_d));
        r_enable_d   = (state_d == ST_SHIFT) && (phase_d == 2'd0);
        panel_clk_d  = (state_d == ST_SHIFT) && (phase_d == 2'd2);
        lat_d        = (state_d == ST_LATCH);
        oe_n_d       = (state_d != ST_DISPLAY);
        frame_done_d = (state_q == ST_DISPLAY) && (state_d == ST_BLANK) && last_plane && last_row;
        row_out_d    = (state_d == ST_LATCH) ? 3'(row_d) : row_out_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            dcnt_q       <= '0;
            rgb1_q       <= '0;
            rgb2_q       <= '0;
            row_out_q    <= '0;
            r_addr_q     <= '0;
            r_enable_q   <= 1'b0;
            panel_clk_q  <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            dcnt_q       <= dcnt_d;
            rgb1_q       <= rgb1_d;
            rgb2_q       <= rgb2_d;
            row_out_q    <= row_out_d;
            r_addr_q     <= r_addr_d;
            r_enable_q   <= r_enable_d;
            panel_clk_q  <= panel_clk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram.r_addr   = r_addr_q;
    assign ram.r_enable = r_enable_q;
    assign o_rgb1       = rgb1_q;
    assign o_rgb2       = rgb2_q;
    assign o_panel_clk  = panel_clk_q;
    assign o_lat        = lat_q;
    assign o_oe_n       = oe_n_q;
    assign o_row        = row_out_q;
    assign o_frame_done = frame_done_q;
endmodule
